// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the round-robin FIFO read scheduler:
//   - arb_state_e : scheduler state encoding (IDLE=0, READ=1, CAPTURE=2, HOLD=3)
//   - clog2()     : ceiling log2 for elaboration-time sizing
//   - qid_w()     : width of a queue index, never less than one bit
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic int qid_w(input int num_q);
    return (clog2(num_q) < 32'sd1) ? 32'sd1 : clog2(num_q);
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick
// Combinational rotating-priority selector. The queue immediately after
// last_grant has the highest priority, wrapping modulo NUM_Q.
// Ports:
//   req        in   NUM_Q  request vector (one bit per non-empty queue)
//   last_grant in   QID_W  queue served most recently
//   hit        out  1      some request is pending
//   idx        out  QID_W  index of the winning queue (0 when no hit)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int QID_W = 2
) (
  input  logic [NUM_Q-1:0] req,
  input  logic [QID_W-1:0] last_grant,
  output logic             hit,
  output logic [QID_W-1:0] idx
);

  // Walk outward from last_grant+1; the first requester found wins.
  always_comb begin
    int cand;
    hit  = 1'b0;
    idx  = '0;
    cand = 32'sd0;
    for (int k = 1; k <= NUM_Q; k++) begin
      cand = (int'(last_grant) + k) % NUM_Q;
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand[QID_W-1:0];
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
// Round-robin read scheduler draining NUM_Q FIFOs into one valid/ready
// stream. A granted queue may deliver up to QUANTUM words before the grant
// rotates; a queue that runs empty rotates early.
// Optional feature macro: FIFO_RR_ARB_STATS_EN adds the xfer_count port.
// Ports:
//   clk         in   1                 rising-edge clock
//   reset       in   1                 synchronous, active-high
//   q_empty     in   NUM_Q             per-FIFO empty flag
//   q_rd_en     out  NUM_Q             per-FIFO read strobe (one-hot or zero)
//   q_dout      in   NUM_Q*DATA_WIDTH  per-FIFO registered read data
//   out_data    out  DATA_WIDTH        captured word
//   out_qid     out  QID_W             source queue of out_data
//   out_valid   out  1                 out_data/out_qid valid
//   out_ready   in  1                  consumer accepts on valid && ready
//   busy        out  1                 scheduler not in IDLE
//   xfer_count  out  16                handshakes since reset (stats build only)
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_Q      = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int QUANTUM    = 4,
  localparam int QID_W      = qid_w(NUM_Q)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_Q-1:0]            q_empty,
  output logic [NUM_Q-1:0]            q_rd_en,
  input  logic [NUM_Q*DATA_WIDTH-1:0] q_dout,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [QID_W-1:0]            out_qid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
`ifdef FIFO_RR_ARB_STATS_EN
  ,
  output logic [15:0]                 xfer_count
`endif
);

  // Burst counter must hold QUANTUM itself (value after the last word).
  localparam int BURST_W = qid_w(QUANTUM + 32'sd1);

  arb_state_e            state_q, state_d;
  logic [QID_W-1:0]      grant_q, grant_d;
  logic [QID_W-1:0]      last_grant_q, last_grant_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [NUM_Q-1:0]      rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [QID_W-1:0]      out_qid_q, out_qid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
`ifdef FIFO_RR_ARB_STATS_EN
  logic [15:0]           xfer_q, xfer_d;
`endif

  logic [NUM_Q-1:0]      req_s;
  logic                  pick_hit_s;
  logic [QID_W-1:0]      pick_idx_s;

  assign req_s = ~q_empty;

  rr_pick #(
    .NUM_Q (NUM_Q),
    .QID_W (QID_W)
  ) u_rr_pick (
    .req        (req_s),
    .last_grant (last_grant_q),
    .hit        (pick_hit_s),
    .idx        (pick_idx_s)
  );

  // Next-state and next-output computation for the scheduler.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    out_data_d   = out_data_q;
    out_qid_d    = out_qid_q;
    out_valid_d  = out_valid_q;
`ifdef FIFO_RR_ARB_STATS_EN
    xfer_d       = xfer_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_hit_s) begin
          grant_d = pick_idx_s;
          burst_d = '0;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // FIFO dout is registered, so the word read in READ is visible now.
        out_data_d  = q_dout[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        out_qid_d   = grant_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          burst_d     = burst_q + BURST_W'(1);
`ifdef FIFO_RR_ARB_STATS_EN
          xfer_d      = xfer_q + 16'd1;
`endif
          if (((int'(burst_q) + 32'sd1) < QUANTUM) && !q_empty[grant_q]) begin
            state_d = READ;
          end else begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read strobe is registered so it is high exactly during READ.
    rd_en_d = '0;
    if (state_d == READ) begin
      rd_en_d[grant_d] = 1'b1;
    end else begin
      rd_en_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= QID_W'(NUM_Q - 1);
      burst_q      <= '0;
      rd_en_q      <= '0;
      out_data_q   <= '0;
      out_qid_q    <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FIFO_RR_ARB_STATS_EN
      xfer_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      rd_en_q      <= rd_en_d;
      out_data_q   <= out_data_d;
      out_qid_q    <= out_qid_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
`ifdef FIFO_RR_ARB_STATS_EN
      xfer_q       <= xfer_d;
`endif
    end
  end

  assign q_rd_en   = rd_en_q;
  assign out_data  = out_data_q;
  assign out_qid   = out_qid_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
`ifdef FIFO_RR_ARB_STATS_EN
  assign xfer_count = xfer_q;
`endif

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin read scheduler that drains NUM_Q independent `fifo` instances into a single valid/ready output stream. It owns every FIFO's `rd_en`, issues reads only to non-empty queues, and captures the FIFO's registered `dout` one cycle after each read. Each winning queue may read up to QUANTUM words before the grant rotates. It sits between the per-source FIFO bank and the shared downstream consumer.

## Interface
- NUM_Q, 4, number of FIFOs served (≥2)
- DATA_WIDTH, 8, word width; must match the FIFOs
- QUANTUM, 4, max words per grant before rotating (≥1; 1 = pure round-robin)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- q_empty  in  NUM_Q  per-FIFO `empty` flag
- q_rd_en  out  NUM_Q  per-FIFO read strobe, at most one bit set
- q_dout  in  NUM_Q*DATA_WIDTH  per-FIFO `dout`, queue i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_data  out  DATA_WIDTH  captured word
- out_qid  out  clog2(NUM_Q)  source queue of out_data
- out_valid  out  1  out_data/out_qid valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  high in any state except IDLE
- xfer_count  out  16  completed transfers (present only with FIFO_RR_ARB_STATS_EN)

## Operation
- Reset values: state IDLE, q_rd_en 0, out_valid 0, out_data 0, out_qid 0, busy 0, burst counter 0, last_grant NUM_Q-1 (so queue 0 has first priority), xfer_count 0.
- States: IDLE, READ, CAPTURE, HOLD.
- IDLE: search queues last_grant+1, last_grant+2, … (mod NUM_Q) for the first with q_empty=0. On a hit: grant ← that queue, burst ← 0, go to READ. With no hit, stay in IDLE.
- READ: q_rd_en[grant]=1 for exactly this cycle (decoded from the state). Then go to CAPTURE.
- CAPTURE: out_data ← q_dout slice of grant, out_qid ← grant, out_valid ← 1. Then go to HOLD.
- HOLD: out_data and out_qid stay stable while out_ready=0. On a handshake: out_valid ← 0, burst ← burst+1, xfer_count+1 (wraps at 2^16).
  - If burst+1 < QUANTUM and q_empty[grant]=0, go to READ.
  - Otherwise last_grant ← grant and go to IDLE.
- The arbiter is the sole reader of every FIFO, so a granted queue cannot become empty before its READ.
- A queue that empties mid-burst rotates early. Writers may fill any queue at any time without affecting the current grant.
- Reset mid-operation: all state returns to reset values on the next edge. A word already read but not yet handed off is dropped.

## Timing
- With out_ready=1, the first word appears 3 cycles after an IDLE cycle that sees a non-empty queue: READ → CAPTURE → HOLD, and out_valid is high in the HOLD cycle.
- Within a burst, back-to-back throughput is one word per 3 cycles (HOLD → READ → CAPTURE → HOLD).
- Rotation adds one IDLE cycle between grants.
- q_empty is sampled in IDLE and HOLD only. q_dout is sampled in CAPTURE only.
- out_valid never drops without a handshake, except on reset.

## Configuration
- FIFO_RR_ARB_STATS_EN:
  - Defined: the 16-bit `xfer_count` port and its counter exist, incrementing once per output handshake and clearing on reset.
  - Undefined: both the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `fifo_arb_pkg`:
  - state encoding constants (IDLE=0, READ=1, CAPTURE=2, HOLD=3)
  - the clog2 function
  - the QID width helper
- Sub-module `rr_pick`: a combinational rotating-priority selector.
  - Inputs: request vector (~q_empty) and last_grant.
  - Outputs: hit and index.

## Test plan
- Reset, then queue 2 holds {0xA1,0xA2} and the others are empty, with out_ready=1 → outputs 0xA1 then 0xA2, both with out_qid=2; first out_valid 3 cycles after IDLE; then returns to IDLE with busy=0.
- QUANTUM=4; queues 0 and 1 each hold 6 words → qid order 0,0,0,0,1,1,1,1,0,0,1,1.
- QUANTUM=1; queues 0, 1 and 3 non-empty → qids 0,1,3,0,1,3… (queue 2 skipped); q_rd_en is never multi-hot.
- out_ready held low for 10 cycles in HOLD → out_data/out_qid stable, no further q_rd_en; on release, exactly one handshake occurs.
- reset pulsed in CAPTURE → next cycle out_valid=0, q_rd_en=0, state IDLE; the next grant goes to queue 0 if it is non-empty.
- With FIFO_RR_ARB_STATS_EN, 300 transfers → xfer_count=300; after reset, xfer_count=0.
